lex_permuter: RTL and testbench
===============================

Name: lex_permuter

Overview:
- Upstream job-assignment generator for the 8-worker/8-job cost search.
- Walks all N! permutations of job indices in lexicographic order, starting from identity.
- For each permutation it issues N (W, J) index pairs, one per cycle, to the cost lookup and accumulator stage.
- It computes the next permutation in a fixed 3-cycle sequence, then waits for the controller's go before the next burst.

Parameters:
- N, 8, number of workers/jobs (permutation length).
- IDX_W, 3, index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- go  input  1  request the next permutation burst; sampled only in IDLE or WAIT.
- ready  output  1  high in IDLE or WAIT; go will be accepted.
- W  output  IDX_W  worker index of the current pair.
- J  output  IDX_W  job index of the current pair, equal to p[W].
- idx_valid  output  1  W/J valid this cycle.
- perm_done  output  1  one-cycle pulse coincident with the W=N-1 pair.
- all_done  output  1  level; final permutation (descending) fully issued.

Behaviour:
- Reset (rst low, asynchronous):
  - p[k]=k; state IDLE; counter 0.
  - W=0, J=0, idx_valid=0, perm_done=0, all_done=0, ready=1.
  - Reset mid-burst or mid-compute abandons all progress. The next go restarts at identity.
- All outputs are registered Moore outputs decoded from state, counter and p. There is no combinational path from go to any output.
- States:
  - IDLE: go=1 at edge -> ISSUE with cnt=0.
  - ISSUE: idx_valid=1, W=cnt, J=p[cnt]. cnt increments each cycle. perm_done=1 when cnt=N-1. After cnt=N-1 -> FIND.
  - FIND: pivot i = largest index with p[i]<p[i+1]. If none exists, the permutation is descending -> DONE. Otherwise register i -> SWAP.
  - SWAP: k = largest index >i with p[k]>p[i]; swap p[i] and p[k] -> REVERSE.
  - REVERSE: reverse p[i+1..N-1] in one cycle -> WAIT.
  - WAIT: go=1 -> ISSUE with cnt=0; otherwise hold.
  - DONE: all_done=1. Held until reset; go is ignored.
- Latency and timing:
  - go sampled at edge t -> first pair (W=0) visible in the cycle after t.
  - The burst lasts exactly N cycles with idx_valid contiguous.
  - With go held high, there are 4 non-valid cycles between bursts (FIND, SWAP, REVERSE, WAIT), giving an N+4 cycle period.
- go asserted in ISSUE/FIND/SWAP/REVERSE is ignored; it is not queued.
- all_done rises 2 cycles after the last pair's cycle (ISSUE -> FIND -> DONE).
- Total bursts = N! (40320 for N=8). The last burst is J=N-1..0.
- Index arithmetic is unsigned IDX_W bits. cnt never wraps inside a burst.
- p always holds a permutation of 0..N-1; this is checked by assertion in simulation.

Optional Feature:
- Macro PERM_COUNT_EN.
- Defined:
  - Adds output perm_cnt [15:0], the number of bursts completed.
  - Resets to 0 and increments on the perm_done cycle.
  - Saturates at 16'hFFFF.
  - Reads 40320 when all_done rises for N=8.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, single go pulse -> W=0..7 and J=0..7 over 8 consecutive cycles, idx_valid high exactly 8 cycles, perm_done only at W=7, ready low during the burst and high 4 cycles after W=7.
- Second go -> J=0,1,2,3,4,5,7,6. Third go -> J=0,1,2,3,4,6,5,7. Fourth go -> J=0,1,2,3,4,6,7,5.
- go held high from reset -> bursts every 12 cycles, 40320 bursts total, last J=7,6,5,4,3,2,1,0. all_done rises 2 cycles later and stays high; further go gives no idx_valid. With PERM_COUNT_EN, perm_cnt=40320.
- go pulses during ISSUE and during SWAP -> no extra burst. The next burst starts only from a go seen in WAIT.
- rst low asynchronously at W=4 of the third burst -> outputs at reset values before the next edge. The next go yields J=0..7 (identity).
- Scoreboard every burst against a software next-permutation model -> no mismatch, each J set is a permutation, no burst repeated.

Source files
------------

// File: rtl/lex_permuter.sv
// -----------------------------------------------------------------------------
// lex_permuter
//
// Purpose:
//   Job-assignment generator for the worker/job cost search. It walks all N!
//   permutations of the job indices in lexicographic order, starting from
//   identity. For each permutation it issues N (W, J) index pairs, one per
//   cycle, with J = p[W]. Between bursts it advances p to the next
//   permutation in three fixed cycles (FIND, SWAP, REVERSE) and then waits
//   in WAIT for the next go.
//
// Optional feature:
//   `define PERM_COUNT_EN adds output perm_cnt[15:0], the saturating count of
//   completed bursts. Without the macro the port and counter do not exist.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   go         in   1      request next burst (only sampled in IDLE / WAIT)
//   ready      out  1      high in IDLE or WAIT
//   W          out  IDX_W  worker index of the current pair
//   J          out  IDX_W  job index of the current pair, p[W]
//   idx_valid  out  1      W/J valid this cycle
//   perm_done  out  1      pulse with the W = N-1 pair
//   all_done   out  1      level, the descending permutation has been issued
//   perm_cnt   out  16     completed bursts (PERM_COUNT_EN only)
//
// All outputs are flops loaded from next-state values, so go has no
// combinational path to any output.
// -----------------------------------------------------------------------------
module lex_permuter #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   output logic             ready,
   output logic [IDX_W-1:0] W,
   output logic [IDX_W-1:0] J,
   output logic             idx_valid,
   output logic             perm_done,
   output logic             all_done
`ifdef PERM_COUNT_EN
   ,
   output logic [15:0]      perm_cnt
`endif
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_FIND,
      S_SWAP,
      S_REVERSE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_cnt_nxt;
   logic [IDX_W-1:0] r_p     [N];
   logic [IDX_W-1:0] w_p_nxt [N];
   logic [IDX_W-1:0] r_piv;
   logic [IDX_W-1:0] w_piv;
   logic             w_found;
   logic [IDX_W-1:0] w_k;

   logic             r_ready;
   logic [IDX_W-1:0] r_W;
   logic [IDX_W-1:0] r_J;
   logic             r_valid;
   logic             r_pdone;
   logic             r_alldone;
   logic             w_valid_nxt;

   // Pivot search: the last ascending adjacent pair wins, giving the largest i.
   always_comb begin
      w_found = 1'b0;
      w_piv   = '0;
      for (int i = 0; i < N - 1; i++) begin
         if (r_p[i] < r_p[i + 1]) begin
            w_found = 1'b1;
            w_piv   = IDX_W'(i);
         end
      end
   end

   // Swap partner: largest k beyond the pivot whose value exceeds p[pivot].
   // The suffix after the pivot is descending, so one always exists.
   always_comb begin
      w_k = '0;
      for (int k = 0; k < N; k++) begin
         if ((k > int'(r_piv)) && (r_p[k] > r_p[r_piv])) begin
            w_k = IDX_W'(k);
         end
      end
   end

   // Permutation update for SWAP and REVERSE.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         w_p_nxt[j] = r_p[j];
      end
      case (r_state)
         S_SWAP: begin
            for (int j = 0; j < N; j++) begin
               if (IDX_W'(j) == r_piv) begin
                  w_p_nxt[j] = r_p[w_k];
               end else if (IDX_W'(j) == w_k) begin
                  w_p_nxt[j] = r_p[r_piv];
               end
            end
         end
         S_REVERSE: begin
            // One mirror network per possible pivot keeps every index constant.
            for (int pv = 0; pv < N - 1; pv++) begin
               if (r_piv == IDX_W'(pv)) begin
                  for (int j = pv + 1; j < N; j++) begin
                     w_p_nxt[j] = r_p[N + pv - j];
                  end
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_WAIT: begin
            if (go) begin
               w_state_nxt = S_ISSUE;
               w_cnt_nxt   = '0;
            end
         end
         S_ISSUE: begin
            if (r_cnt == LAST) begin
               w_state_nxt = S_FIND;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + IDX_W'(1);
            end
         end
         S_FIND: begin
            w_state_nxt = w_found ? S_SWAP : S_DONE;
         end
         S_SWAP: begin
            w_state_nxt = S_REVERSE;
         end
         S_REVERSE: begin
            w_state_nxt = S_WAIT;
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_valid_nxt = (w_state_nxt == S_ISSUE);

   // State, permutation and pivot registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_piv   <= '0;
         for (int j = 0; j < N; j++) begin
            r_p[j] <= IDX_W'(j);
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == S_FIND) begin
            r_piv <= w_piv;
         end
         for (int j = 0; j < N; j++) begin
            r_p[j] <= w_p_nxt[j];
         end
      end
   end

   // Registered Moore outputs. p is stable whenever the next state is ISSUE,
   // so J can be looked up from the current p. W/J read 0 outside a burst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready   <= 1'b1;
         r_W       <= '0;
         r_J       <= '0;
         r_valid   <= 1'b0;
         r_pdone   <= 1'b0;
         r_alldone <= 1'b0;
      end else begin
         r_ready   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT);
         r_W       <= w_valid_nxt ? w_cnt_nxt : '0;
         r_J       <= w_valid_nxt ? r_p[w_cnt_nxt] : '0;
         r_valid   <= w_valid_nxt;
         r_pdone   <= w_valid_nxt && (w_cnt_nxt == LAST);
         r_alldone <= (w_state_nxt == S_DONE);
      end
   end

   assign ready     = r_ready;
   assign W         = r_W;
   assign J         = r_J;
   assign idx_valid = r_valid;
   assign perm_done = r_pdone;
   assign all_done  = r_alldone;

`ifdef PERM_COUNT_EN
   logic [15:0] r_perm_cnt;

   // Counts on the perm_done cycle, so the total is visible from FIND onward.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perm_cnt <= '0;
      end else if (r_pdone && (r_perm_cnt != 16'hFFFF)) begin
         r_perm_cnt <= r_perm_cnt + 16'd1;
      end
   end

   assign perm_cnt = r_perm_cnt;
`endif

   // Every value 0..N-1 must appear somewhere in p.
   logic [N-1:0] w_seen;

   always_comb begin
      w_seen = '0;
      for (int v = 0; v < N; v++) begin
         for (int k = 0; k < N; k++) begin
            if (r_p[k] == IDX_W'(v)) begin
               w_seen[v] = 1'b1;
            end
         end
      end
   end

   a_p_is_perm : assert property (@(posedge clk) disable iff (!rst) (&w_seen));

endmodule

// File: tb/tb_lex_permuter.sv
// -----------------------------------------------------------------------------
// tb_lex_permuter
//
// Directed and exhaustive checks of lex_permuter. An N=8 instance covers the
// burst timing, go filtering and asynchronous reset; an N=6 instance is run
// through all 720 permutations with go held high. Expected J sequences come
// from unranking the burst number in the factorial number system.
// -----------------------------------------------------------------------------
module tb_lex_permuter;

   logic       clk = 1'b0;
   logic       rst;
   logic       go8;
   logic       go6;
   logic       rdy8, v8, pd8, ad8;
   logic [2:0] W8, J8;
   logic       rdy6, v6, pd6, ad6;
   logic [2:0] W6, J6;
`ifdef PERM_COUNT_EN
   logic [15:0] pc8;
   logic [15:0] pc6;
`endif

   always #5 clk = ~clk;

   lex_permuter #(.N(8), .IDX_W(3)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .go        (go8),
      .ready     (rdy8),
      .W         (W8),
      .J         (J8),
      .idx_valid (v8),
      .perm_done (pd8),
      .all_done  (ad8)
`ifdef PERM_COUNT_EN
      ,
      .perm_cnt  (pc8)
`endif
   );

   lex_permuter #(.N(6), .IDX_W(3)) u_dut6 (
      .clk       (clk),
      .rst       (rst),
      .go        (go6),
      .ready     (rdy6),
      .W         (W6),
      .J         (J6),
      .idx_valid (v6),
      .perm_done (pd6),
      .all_done  (ad6)
`ifdef PERM_COUNT_EN
      ,
      .perm_cnt  (pc6)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;
   int exp_j[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int b, input int c,
                      input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s burst=%0d idx=%0d observed=%0h expected=%0h", tag, b, c, obs, expv);
      end
   endtask

   // r-th permutation (0-based, lexicographic) of 0..n-1.
   task automatic unrank(input int n, input int r);
      int q[$];
      int f;
      int d;
      int rem;
      q   = {};
      rem = r;
      for (int v = 0; v < n; v++) q.push_back(v);
      for (int pos = 0; pos < n; pos++) begin
         f = 1;
         for (int t = 2; t <= n - 1 - pos; t++) f = f * t;
         d = rem / f;
         rem = rem % f;
         exp_j[pos] = q[d];
         q.delete(d);
      end
   endtask

   // One go pulse from IDLE/WAIT, the burst and the three compute cycles,
   // ending in WAIT. Optional stray go pulses land in ISSUE and SWAP.
   task automatic burst8(input int b, input bit pulse_issue, input bit pulse_swap);
      unrank(8, b);
      go8 = 1'b1;
      tick();
      go8 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk("valid8", b, c, v8, 1);
         chk("W8", b, c, W8, c);
         chk("J8", b, c, J8, exp_j[c]);
         chk("perm_done8", b, c, pd8, (c == 7) ? 1 : 0);
         chk("ready8_busy", b, c, rdy8, 0);
         if (pulse_issue && c == 2) go8 = 1'b1;
         tick();
         go8 = 1'b0;
      end
      chk("ready8_find", b, 8, rdy8, 0);
      chk("valid8_find", b, 8, v8, 0);
      tick();
      chk("ready8_swap", b, 9, rdy8, 0);
      if (pulse_swap) go8 = 1'b1;
      tick();
      go8 = 1'b0;
      chk("ready8_rev", b, 10, rdy8, 0);
      chk("valid8_rev", b, 10, v8, 0);
      tick();
      chk("ready8_wait", b, 11, rdy8, 1);
      chk("valid8_wait", b, 11, v8, 0);
      if (pulse_issue || pulse_swap) begin
         for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_extra_burst", b, 12 + i, v8, 0);
            chk("ready8_hold", b, 12 + i, rdy8, 1);
         end
      end
   endtask

   initial begin
      int gap;
      int mask;

      rst = 1'b0;
      go8 = 1'b0;
      go6 = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_ready8", 0, 0, rdy8, 1);
      chk("rst_valid8", 0, 0, v8, 0);
      chk("rst_W8", 0, 0, W8, 0);
      chk("rst_J8", 0, 0, J8, 0);
      chk("rst_pdone8", 0, 0, pd8, 0);
      chk("rst_alldone8", 0, 0, ad8, 0);
      chk("rst_ready6", 0, 0, rdy6, 1);
      chk("rst_valid6", 0, 0, v6, 0);
      rst = 1'b1;
      tick();
      chk("idle_valid8", 0, 0, v8, 0);

      // First four permutations, then stray go pulses in ISSUE and SWAP
      for (int b = 0; b < 4; b++) burst8(b, 1'b0, 1'b0);
      burst8(4, 1'b1, 1'b1);

      // Asynchronous reset in the middle of the third burst
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      burst8(0, 1'b0, 1'b0);
      burst8(1, 1'b0, 1'b0);
      go8 = 1'b1;
      tick();
      go8 = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("W8_before_rst", 2, 4, W8, 4);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid8", 2, 4, v8, 0);
      chk("arst_W8", 2, 4, W8, 0);
      chk("arst_J8", 2, 4, J8, 0);
      chk("arst_ready8", 2, 4, rdy8, 1);
      chk("arst_pdone8", 2, 4, pd8, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      burst8(0, 1'b0, 1'b0);
`ifdef PERM_COUNT_EN
      chk("perm_cnt8", 0, 0, pc8, 1);
`endif

      // Exhaustive walk on the N=6 instance with go held high
      go6 = 1'b1;
      tick();
      for (int b = 0; b < 720; b++) begin
         if (b > 0) begin
            gap = 0;
            while (!v6 && gap < 20) begin
               tick();
               gap++;
            end
            chk("gap6", b, 0, gap, 4);
         end
         unrank(6, b);
         mask = 0;
         for (int c = 0; c < 6; c++) begin
            chk("valid6", b, c, v6, 1);
            chk("W6", b, c, W6, c);
            chk("J6", b, c, J6, exp_j[c]);
            chk("perm_done6", b, c, pd6, (c == 5) ? 1 : 0);
            mask = mask | (1 << J6);
            tick();
         end
         chk("perm_set6", b, 0, mask, 63);
      end
      chk("alldone6_find", 720, 0, ad6, 0);
      tick();
      chk("alldone6_rise", 720, 1, ad6, 1);
      chk("ready6_done", 720, 1, rdy6, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("valid6_done", 720, 2 + i, v6, 0);
         chk("alldone6_hold", 720, 2 + i, ad6, 1);
      end
`ifdef PERM_COUNT_EN
      chk("perm_cnt6", 720, 0, pc6, 720);
`endif
      go6 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
